// File: rtl/cpu_datapath.sv
// Execution datapath: 8-entry register file, A/B/C pipeline registers, shifter,
// ALU and Z/N/V status register, sequenced by the CPU controller's strobes.
`timescale 1ns/1ps

module cpu_datapath #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mdata,
    input  logic [DATA_W-1:0] sximm8,
    input  logic [DATA_W-1:0] sximm5,
    input  logic [7:0]        pc,
    input  logic [1:0]        vsel,
    input  logic              write,
    input  logic [2:0]        writenum,
    input  logic [2:0]        readnum,
    input  logic              loada,
    input  logic              loadb,
    input  logic              loadc,
    input  logic              loads,
    input  logic              asel,
    input  logic              bsel,
    input  logic [1:0]        shift,
    input  logic [1:0]        ALUop,
    output logic [DATA_W-1:0] datapath_out,
    output logic              Z_out,
    output logic              N_out,
    output logic              V_out
);

    localparam int NUM_REGS = 8;

    // Low until the first edge after reset release, so that edge changes nothing.
    logic run_reg;

    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] c_reg;
    logic              z_reg;
    logic              n_reg;
    logic              v_reg;

    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] rf_word [NUM_REGS];
    logic [DATA_W-1:0] shift_out;
    logic [DATA_W-1:0] ain;
    logic [DATA_W-1:0] bin;
    logic [DATA_W-1:0] alu_out;
    logic              z_next;
    logic              n_next;
    logic              v_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    // Writeback source; uses C's pre-edge value, so loadc plus write stores the old C.
    always_comb begin
        wb_data = c_reg;
        case (vsel)
            2'b00:   wb_data = c_reg;
            2'b01:   wb_data = {{(DATA_W-8){1'b0}}, pc};
            2'b10:   wb_data = sximm8;
            default: wb_data = mdata;
        endcase
    end

    // Register file kept in flops (not RAM) because it must clear asynchronously.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf
        logic [DATA_W-1:0] r_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_reg <= '0;
            end else if (run_reg && write && (writenum == 3'(gi))) begin
                r_reg <= wb_data;
            end
        end

        assign rf_word[gi] = r_reg;
    end

    // Combinational read returns the pre-edge value; there is no write bypass.
    assign read_data = rf_word[readnum];

    always_comb begin
        shift_out = b_reg;
        case (shift)
            2'b00:   shift_out = b_reg;
            2'b01:   shift_out = {b_reg[DATA_W-2:0], 1'b0};
            2'b10:   shift_out = {1'b0, b_reg[DATA_W-1:1]};
            default: shift_out = {b_reg[DATA_W-1], b_reg[DATA_W-1:1]};
        endcase
    end

    assign ain = asel ? '0 : a_reg;
    assign bin = bsel ? sximm5 : shift_out;

    always_comb begin
        alu_out = '0;
        v_next  = 1'b0;
        case (ALUop)
            2'b00: begin
                alu_out = ain + bin;
                v_next  = (ain[DATA_W-1] == bin[DATA_W-1]) &&
                          (alu_out[DATA_W-1] != ain[DATA_W-1]);
            end
            2'b01: begin
                alu_out = ain - bin;
                v_next  = (ain[DATA_W-1] != bin[DATA_W-1]) &&
                          (alu_out[DATA_W-1] != ain[DATA_W-1]);
            end
            2'b10: begin
                alu_out = ain & bin;
            end
            default: begin
                alu_out = ~bin;
            end
        endcase
    end

    assign z_next = (alu_out == '0);
    assign n_next = alu_out[DATA_W-1];

    // Each strobe acts independently; any combination may fire on one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
            z_reg <= 1'b0;
            n_reg <= 1'b0;
            v_reg <= 1'b0;
        end else if (run_reg) begin
            if (loada) begin
                a_reg <= read_data;
            end
            if (loadb) begin
                b_reg <= read_data;
            end
            if (loadc) begin
                c_reg <= alu_out;
            end
            if (loads) begin
                z_reg <= z_next;
                n_reg <= n_next;
                v_reg <= v_next;
            end
        end
    end

    assign datapath_out = c_reg;
    assign Z_out        = z_reg;
    assign N_out        = n_reg;
    assign V_out        = v_reg;

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Execution datapath driven cycle-by-cycle by the CPU FSM controller; consumes its loada/loadb/loadc/loads/asel/bsel/shift/vsel/write/writenum/readnum strobes.
- Contains an 8-entry register file, A/B/C pipeline registers, a shifter, an ALU and a registered status (Z/N/V) register.
- C is the block's data result; status feeds CMP handling in the controller.

Parameters:
- DATA_W, 16, datapath word width (register file entries, A, B, C, ALU).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- mdata  input  DATA_W  memory read data (writeback source)
- sximm8  input  DATA_W  sign-extended 8-bit immediate (writeback source)
- sximm5  input  DATA_W  sign-extended 5-bit immediate (ALU B-side source)
- pc  input  8  program counter, zero-extended to DATA_W for writeback
- vsel  input  2  writeback select: 00 C, 01 pc, 10 sximm8, 11 mdata
- write  input  1  register-file write enable
- writenum  input  3  register-file write index
- readnum  input  3  register-file read index
- loada  input  1  load A from read port
- loadb  input  1  load B from read port
- loadc  input  1  load C from ALU result
- loads  input  1  load status from ALU flags
- asel  input  1  1: ALU A-input forced to 0; 0: A register
- bsel  input  1  1: ALU B-input = sximm5; 0: shifter output
- shift  input  2  shifter op on B
- ALUop  input  2  00 add, 01 sub, 10 and, 11 not-B
- datapath_out  output  DATA_W  C register
- Z_out  output  1  zero flag
- N_out  output  1  negative flag
- V_out  output  1  signed overflow flag

Behaviour:
- Reset (reset=0, asynchronous): all 8 registers, A, B, C, Z/N/V cleared to 0 immediately, independent of clk. All outputs read 0 while reset is held. Release is synchronous to the next rising edge; no state changes on the release edge itself.
- Register file: combinational read of R[readnum]. On a rising edge with write=1, R[writenum] takes the writeback value.
- Read and write to the same index in the same cycle: the read sees the old value (no bypass).
- Writeback mux (vsel): 00 C, 01 {0,pc}, 10 sximm8, 11 mdata. It uses C's pre-edge value; loadc and write=1/vsel=00 on the same edge write the old C.
- A, B, C, status: each updates only on a rising edge with its load strobe set, otherwise holds. Any combination of strobes may be asserted together; each acts independently on the same edge.
- Shifter on B: 00 pass; 01 left by 1, fill 0; 10 logical right by 1, fill 0; 11 arithmetic right by 1 (MSB replicated).
- ALU, DATA_W bits, result truncated:
  - add: Ain+Bin
  - sub: Ain-Bin (two's complement)
  - and: Ain&Bin
  - not-B: ~Bin (Ain ignored)
- Flags, computed combinationally from the ALU and captured on loads:
  - Z = result==0
  - N = result MSB
  - V = signed overflow for add/sub (operands same sign differing from result for add; opposite signs with result sign ≠ Ain sign for sub); V=0 for and/not.
- Latency:
  - Register to A/B: 1 edge.
  - A/B to C/status: 1 edge.
  - C to register file: 1 edge.
  - Register-to-register ADD takes 4 edges (getA, getB, add, write), matching the controller sequence.
- Reset asserted mid-sequence discards all partial results. No X ever propagates from an unwritten register, because the file is reset.

Test Plan:
- Reset then immediate loads: hold reset=0, pulse clk with write=1 → all registers read 0, datapath_out=0, Z/N/V=0. Assert reset while C=0x1234 → datapath_out=0 before the next edge.
- MOV immediate: sximm8=0x0007, vsel=10, writenum=0, write=1 → R0=7. Then sximm8=0xFFFE into R1 → R1=0xFFFE.
- ADD with shift: R0=7, R1=2. Load A←R0, B←R1, shift=01, ALUop=00, loadc, then write R2 with vsel=00 → R2=0x000B, Z=0, N=0, V=0.
- CMP overflow: A=0x7FFF, B=0xFFFF, ALUop=01, loads=1 → result 0x8000, N=1, Z=0, V=1. Equal operands 5-5 → Z=1, N=0, V=0.
- Same-cycle hazards: R3=0x0010, write R3←0x0020 while readnum=3 and loada=1 → A=0x0010, R3=0x0020. loadc with new result plus write vsel=00 on the same edge → register gets the prior C.
- AND/MVN and immediate B: A=0x00F0, bsel=1, sximm5=0xFFFF, ALUop=10 → C=0x00F0. Shifter B=0x8001, shift=11, ALUop=11 → C=~0xC000=0x3FFF, V=0.
